seg7_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display. It decodes a packed hex value into active-low segment patterns and scans one digit at a time. New values are double-buffered, so a value change only takes effect at a frame boundary and never tears mid-frame. It sits between the datapath (`top`) and the board pins, and supersedes the single-digit `segout` path.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_prescaler.sv | 31 +++
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit map, blank/anode-off constants and the hex-to-segment
// decoder shared by the 7-segment scan driver.
package seg7_pkg;

   localparam int SEG_DP = 7;
   localparam int SEG_A  = 6;
   localparam int SEG_G  = 0;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic       AN_OFF    = 1'b1;

   // Active-low a..g pattern for one hex nibble (bit 6 = a, bit 0 = g).
   function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h01;
         4'h1:    seg = 7'h4F;
         4'h2:    seg = 7'h12;
         4'h3:    seg = 7'h06;
         4'h4:    seg = 7'h4C;
         4'h5:    seg = 7'h24;
         4'h6:    seg = 7'h20;
         4'h7:    seg = 7'h0F;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h04;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h60;
         4'hC:    seg = 7'h31;
         4'hD:    seg = 7'h42;
         4'hE:    seg = 7'h30;
         4'hF:    seg = 7'h38;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// seg7_prescaler: per-slot cycle counter; flags the last cycle of a slot and
// the dead-time cycles at its start.
module seg7_prescaler #(
   parameter int DIV   = 1000,
   parameter int BLANK = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tc,
   output logic in_blank
);

   localparam int CNT_W = $clog2(DIV);

   logic [CNT_W-1:0] r_cnt;

   assign tc       = (r_cnt == CNT_W'(DIV - 1));
   assign in_blank = (r_cnt < CNT_W'(BLANK));

   // Slot cycle counter, wraps on terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed N-digit common-anode
// 7-segment driver. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*N_DIGITS-1:0]   value,
   input  logic [N_DIGITS-1:0]     dp,
   input  logic                    load,
   output logic [7:0]              segout,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_tick
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic                  w_tc;
   logic                  w_in_blank;
   logic                  w_wrap;
   logic [IDX_W-1:0]      r_idx;
   logic [4*N_DIGITS-1:0] r_act_val;
   logic [N_DIGITS-1:0]   r_act_dp;
   logic [4*N_DIGITS-1:0] r_pend_val;
   logic [N_DIGITS-1:0]   r_pend_dp;
   logic                  r_pend_v;
   logic [N_DIGITS-1:0]   w_lzb;
   logic [3:0]            w_nib;
   logic [7:0]            w_seg;
   logic [N_DIGITS-1:0]   w_an;

   seg7_prescaler #(
      .DIV   (SCAN_DIV),
      .BLANK (BLANK_CYC)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .tc       (w_tc),
      .in_blank (w_in_blank)
   );

   assign w_wrap = w_tc && (r_idx == IDX_LAST);

`ifdef SEG7_LZB_EN
   // Blank the run of zero nibbles from the MSD down; digit 0 always shows.
   function automatic logic [N_DIGITS-1:0] lzb_mask(input logic [4*N_DIGITS-1:0] v);
      logic [N_DIGITS-1:0] m;
      logic                lead;
      m    = '0;
      lead = 1'b1;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         if (lead && (i != 0) && (v[4*i +: 4] == 4'h0)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
            lead = 1'b0;
         end
      end
      return m;
   endfunction

   assign w_lzb = lzb_mask(r_act_val);
`else
   assign w_lzb = '0;
`endif

   // Segment/anode pattern for the current slot, from the active buffer.
   always_comb begin
      w_nib = r_act_val[{r_idx, 2'b00} +: 4];
      w_seg = {1'b1, SEG_BLANK};
      w_an  = {N_DIGITS{AN_OFF}};
      if (!w_in_blank) begin
         w_an[r_idx]   = ~AN_OFF;
         w_seg[SEG_DP] = ~r_act_dp[r_idx];
         if (w_lzb[r_idx]) begin
            w_seg[SEG_A:SEG_G] = SEG_BLANK;
         end else begin
            w_seg[SEG_A:SEG_G] = seg7_decode(w_nib);
         end
      end else begin
         w_seg = {1'b1, SEG_BLANK};
         w_an  = {N_DIGITS{AN_OFF}};
      end
   end

   // Digit index, pending buffer capture and frame-boundary transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx      <= '0;
         r_act_val  <= '0;
         r_act_dp   <= '0;
         r_pend_val <= '0;
         r_pend_dp  <= '0;
         r_pend_v   <= 1'b0;
      end else begin
         if (w_tc) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
         end
         if (w_wrap && r_pend_v) begin
            r_act_val <= r_pend_val;
            r_act_dp  <= r_pend_dp;
         end
         // A load on the boundary cycle stays pending for the next frame.
         if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp;
            r_pend_v   <= 1'b1;
         end else if (w_wrap) begin
            r_pend_v <= 1'b0;
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         segout     <= 8'hFF;
         an         <= {N_DIGITS{AN_OFF}};
         frame_tick <= 1'b0;
      end else begin
         segout     <= w_seg;
         an         <= w_an;
         frame_tick <= w_wrap;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed plus randomized stimulus against a cycle-count
// reference model of the scan driver (honours SEG7_LZB_EN when defined).
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int SD = 4;
   localparam int BL = 1;
   localparam int FL = N * SD;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [7:0]  segout;
   logic [3:0]  an;
   logic        frame_tick;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] m_act, m_pend;
   logic [3:0]  m_act_dp, m_pend_dp;
   logic        m_pv;
   int          m_k;
   logic [7:0]  e_seg;
   logic [3:0]  e_an;
   logic        e_ft;
   logic        saw_cf;
   logic [7:0]  hex_tab [16];

   seg7_scan_driver #(
      .N_DIGITS  (N),
      .SCAN_DIV  (SD),
      .BLANK_CYC (BL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp         (dp),
      .load       (load),
      .segout     (segout),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_blanked(input logic [15:0] v, input int d);
`ifdef SEG7_LZB_EN
      if (d == 0) return 1'b0;
      return (v >> (4 * d)) == 16'h0000;
`else
      return 1'b0;
`endif
   endfunction

   // One clock: model the edge from the time position in the frame, then compare.
   task automatic tick();
      int c, d;
      logic [3:0] nib;
      @(posedge clk);
      #1;
      if (rst) begin
         m_k = 0; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 1'b0;
         e_seg = 8'hFF; e_an = 4'hF; e_ft = 1'b0;
      end else begin
         c    = m_k % SD;
         d    = (m_k / SD) % N;
         e_ft = ((m_k % FL) == FL - 1);
         if (c < BL) begin
            e_seg = 8'hFF;
            e_an  = 4'hF;
         end else begin
            e_an    = 4'hF;
            e_an[d] = 1'b0;
            nib     = m_act[4*d +: 4];
            e_seg   = is_blanked(m_act, d) ? 8'hFF : hex_tab[nib];
            e_seg[7] = ~m_act_dp[d];
         end
         if (e_ft && m_pv) begin
            m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 1'b0;
         end
         if (load) begin
            m_pend = value; m_pend_dp = dp; m_pv = 1'b1;
         end
         m_k++;
      end
      if (segout == 8'hCF) saw_cf = 1'b1;
      check_eq("segout", 16'(segout), 16'(e_seg));
      check_eq("an", 16'(an), 16'(e_an));
      check_eq("frame_tick", 16'(frame_tick), 16'(e_ft));
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v; dp = d; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_boundary();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!frame_tick && n < 2 * FL);
      check_eq("boundary_seen", 16'(frame_tick), 16'h0001);
   endtask

   // Starting on a frame_tick cycle, check the non-blank cycle of each slot.
   task automatic show_frame(input string tag, input logic [31:0] segs);
      logic [3:0] a;
      tick();
      for (int j = 0; j < N; j++) begin
         tick();
         a    = 4'hF;
         a[j] = 1'b0;
         check_eq({tag, "_an"}, 16'(an), 16'(a));
         check_eq({tag, "_seg"}, 16'(segout), 16'(segs[8*j +: 8]));
         repeat (3) tick();
      end
   endtask

   initial begin
      int n;
      hex_tab = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                  8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8};
      saw_cf = 1'b0;
      rst = 1'b1; load = 1'b0; value = 16'h0000; dp = 4'h0;
      tick();
      tick();
      check_eq("rst_seg", 16'(segout), 16'h00FF);
      check_eq("rst_an", 16'(an), 16'h000F);
      check_eq("rst_ft", 16'(frame_tick), 16'h0000);
      rst = 1'b0;

      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_tick && n < 40);
      check_eq("first_tick_delay", 16'(n), 16'd16);

      do_load(16'h7F01, 4'h0);
      wait_boundary();
      show_frame("basic", {8'h8F, 8'hB8, 8'h81, 8'hCF});

      do_load(16'h0008, 4'b0001);
      wait_boundary();
      tick();
      tick();
      check_eq("dp_an", 16'(an), 16'h000E);
      check_eq("dp_seg", 16'(segout), 16'h0000);

      do_load(16'h0041, 4'h0);
      wait_boundary();
`ifdef SEG7_LZB_EN
      show_frame("lzb41", {8'hFF, 8'hFF, 8'hCC, 8'hCF});
`else
      show_frame("nolzb41", {8'h81, 8'h81, 8'hCC, 8'hCF});
`endif
      do_load(16'h0000, 4'h0);
      wait_boundary();
`ifdef SEG7_LZB_EN
      show_frame("lzb0", {8'hFF, 8'hFF, 8'hFF, 8'h81});
`else
      show_frame("nolzb0", {8'h81, 8'h81, 8'h81, 8'h81});
`endif

      saw_cf = 1'b0;
      while (m_k % FL != 6) tick();
      do_load(16'h1111, 4'h0);
      repeat (3) tick();
      do_load(16'h8888, 4'h0);
      wait_boundary();
      show_frame("dbuf", {8'h80, 8'h80, 8'h80, 8'h80});
      while (m_k % FL != FL - 1) tick();
      do_load(16'h4444, 4'h0);
      show_frame("defer_old", {8'h80, 8'h80, 8'h80, 8'h80});
      show_frame("defer_new", {8'hCC, 8'hCC, 8'hCC, 8'hCC});
      check_eq("no_cf_seen", 16'(saw_cf), 16'h0000);

      while (m_k % FL != 9) tick();
      rst = 1'b1; value = 16'h1234; dp = 4'hF; load = 1'b1;
      tick();
      check_eq("midrst_seg", 16'(segout), 16'h00FF);
      check_eq("midrst_an", 16'(an), 16'h000F);
      rst = 1'b0; load = 1'b0;
      tick();
      tick();
      check_eq("restart_an", 16'(an), 16'h000E);
      check_eq("restart_seg", 16'(segout), 16'h0081);
      repeat (2 * FL) tick();

      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 499) == 0);
         load  = ($urandom_range(0, 9) == 0);
         value = 16'($urandom);
         dp    = 4'($urandom);
         tick();
      end
      rst = 1'b0; load = 1'b0;
      repeat (FL) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
